// File: rtl/incubator_pkg.sv
// Shared types for the incubator profile controller: FSM encoding and the
// 8-bit sensor / 10-bit comparison temperature types.
package incubator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef logic signed [7:0] temp_t;
    typedef logic signed [9:0] cmp_t;

    // Widening by two bits keeps sp +/- HYST (HYST <= 15) clear of wrap-around.
    function automatic cmp_t widen(input logic [7:0] v);
        return cmp_t'({{2{v[7]}}, v});
    endfunction

endpackage

// File: rtl/incubator_actuator.sv
// Hysteresis heater/cooler request logic with mutual exclusion; defining
// INCUBATOR_DWELL_EN adds a minimum-dwell counter per actuator.
module incubator_actuator
    import incubator_pkg::*;
#(
    parameter int HYST      = 2,
    parameter int MIN_DWELL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  logic [7:0] temperature_i,
    input  logic [7:0] setpoint_i,
    output logic       heater_o,
    output logic       cooler_o
);

    localparam cmp_t HYST_W = cmp_t'(HYST);

    cmp_t t_w;
    cmp_t sp_w;
    logic heat_set;
    logic heat_clr;
    logic cool_set;
    logic cool_clr;
    logic req_h_q;
    logic req_h_d;
    logic req_c_q;
    logic req_c_d;

    assign t_w      = widen(temperature_i);
    assign sp_w     = widen(setpoint_i);
    assign heat_set = t_w < (sp_w - HYST_W);
    assign heat_clr = t_w >= sp_w;
    assign cool_set = t_w > (sp_w + HYST_W);
    assign cool_clr = t_w <= sp_w;

    always_comb begin
        req_h_d = req_h_q;
        req_c_d = req_c_q;
        if (heat_set) begin
            req_h_d = 1'b1;
            req_c_d = 1'b0;
        end else if (cool_set) begin
            req_c_d = 1'b1;
            req_h_d = 1'b0;
        end else begin
            if (heat_clr) req_h_d = 1'b0;
            if (cool_clr) req_c_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_h_q <= 1'b0;
            req_c_q <= 1'b0;
        end else if (!enable_i) begin
            req_h_q <= 1'b0;
            req_c_q <= 1'b0;
        end else begin
            req_h_q <= req_h_d;
            req_c_q <= req_c_d;
        end
    end

`ifdef INCUBATOR_DWELL_EN
    localparam int CW = $clog2(MIN_DWELL + 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(MIN_DWELL - 1);

    logic          heat_q;
    logic          cool_q;
    logic [CW-1:0] h_cnt_q;
    logic [CW-1:0] c_cnt_q;

    // Outputs track the next request so dwell adds no latency when idle; a
    // turn-on only proceeds once the opposite actuator is free to drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            heat_q  <= 1'b0;
            cool_q  <= 1'b0;
            h_cnt_q <= '0;
            c_cnt_q <= '0;
        end else if (!enable_i) begin
            heat_q  <= 1'b0;
            cool_q  <= 1'b0;
            h_cnt_q <= '0;
            c_cnt_q <= '0;
        end else begin
            if (h_cnt_q != '0) h_cnt_q <= h_cnt_q - CW'(1);
            if (c_cnt_q != '0) c_cnt_q <= c_cnt_q - CW'(1);
            if (h_cnt_q == '0 && req_h_d != heat_q) begin
                if (!req_h_d || !cool_q || c_cnt_q == '0) begin
                    heat_q  <= req_h_d;
                    h_cnt_q <= DWELL_LOAD;
                end
            end
            if (c_cnt_q == '0 && req_c_d != cool_q) begin
                if (!req_c_d || !heat_q || h_cnt_q == '0) begin
                    cool_q  <= req_c_d;
                    c_cnt_q <= DWELL_LOAD;
                end
            end
        end
    end

    assign heater_o = heat_q;
    assign cooler_o = cool_q;
`else
    assign heater_o = req_h_q;
    assign cooler_o = req_c_q;
`endif

endmodule

// File: rtl/incubator_profile_ctrl.sv
// Runs a programmable {setpoint, hold} temperature profile and drives the
// heater/cooler pair; INCUBATOR_DWELL_EN enables minimum actuator dwell.
module incubator_profile_ctrl
    import incubator_pkg::*;
#(
    parameter int STEPS     = 4,
    parameter int HOLD_W    = 8,
    parameter int HYST      = 2,
    parameter int MIN_DWELL = 4,
    localparam int STEP_W   = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        temperature,
    input  logic              tick,
    input  logic              prog_we,
    input  logic [STEP_W-1:0] prog_addr,
    input  logic [7:0]        prog_setpoint,
    input  logic [HOLD_W-1:0] prog_hold,
    output logic              heater,
    output logic              cooler,
    output logic [STEP_W-1:0] step,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
    localparam cmp_t HYST_W = cmp_t'(HYST);

    logic [7:0]        sp_q   [STEPS];
    logic [HOLD_W-1:0] hold_q [STEPS];

    state_e            state_q;
    logic [STEP_W-1:0] step_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              busy_q;
    logic              done_q;

    logic [7:0]        sp_sel;
    logic [HOLD_W-1:0] hold_sel;
    cmp_t              t_w;
    cmp_t              sp_w;
    logic              in_band;
    logic              finishing;
    logic              reg_enable;

    assign sp_sel   = sp_q[step_q];
    assign hold_sel = hold_q[step_q];
    assign t_w      = widen(temperature);
    assign sp_w     = widen(sp_sel);
    assign in_band  = (t_w >= sp_w - HYST_W) && (t_w <= sp_w + HYST_W);

    // Regulation drops in the same edge that leaves RAMP/HOLD, so abort and
    // profile completion switch the actuators off without a cycle of lag.
    assign finishing  = (state_q == ST_HOLD) && (hold_cnt_q == '0) && (step_q == LAST_STEP);
    assign reg_enable = ((state_q == ST_RAMP) || (state_q == ST_HOLD)) && !abort && !finishing;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STEPS; i++) begin
                sp_q[i]   <= '0;
                hold_q[i] <= '0;
            end
        end else if (prog_we && !busy_q) begin
            sp_q[prog_addr]   <= prog_setpoint;
            hold_q[prog_addr] <= prog_hold;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_q <= ST_RAMP;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        step_q  <= '0;
                        busy_q  <= 1'b0;
                    end else if (in_band) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= hold_sel;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        step_q  <= '0;
                        busy_q  <= 1'b0;
                    end else if (hold_cnt_q == '0) begin
                        if (step_q == LAST_STEP) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RAMP;
                            step_q  <= step_q + STEP_W'(1);
                        end
                    end else if (tick) begin
                        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    step_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    incubator_actuator #(
        .HYST      (HYST),
        .MIN_DWELL (MIN_DWELL)
    ) u_actuator (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (reg_enable),
        .temperature_i (temperature),
        .setpoint_i    (sp_sel),
        .heater_o      (heater),
        .cooler_o      (cooler)
    );

    assign step  = step_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_incubator_profile_ctrl.sv
// Directed bench for incubator_profile_ctrl: profile sequencing, hysteresis,
// abort, table write protection, dwell behaviour and signed boundaries.
module tb_incubator_profile_ctrl;

`ifdef INCUBATOR_DWELL_EN
    localparam bit DWELL = 1'b1;
`else
    localparam bit DWELL = 1'b0;
`endif
    localparam int SETTLE = DWELL ? 3 : 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] temperature;
    logic       tick;
    logic       prog_we;
    logic [1:0] prog_addr;
    logic [7:0] prog_setpoint;
    logic [7:0] prog_hold;
    logic       heater;
    logic       cooler;
    logic [1:0] step;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int n_checks = 0;
    int n_fails  = 0;

    incubator_profile_ctrl #(
        .STEPS(4), .HOLD_W(8), .HYST(2), .MIN_DWELL(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .temperature   (temperature),
        .tick          (tick),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_setpoint (prog_setpoint),
        .prog_hold     (prog_hold),
        .heater        (heater),
        .cooler        (cooler),
        .step          (step),
        .busy          (busy),
        .done          (done),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic prog(input logic [1:0] addr, input logic [7:0] sp, input logic [7:0] hold);
        prog_we = 1'b1; prog_addr = addr; prog_setpoint = sp; prog_hold = hold;
        cyc(1);
        prog_we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; abort = 1'b0; tick = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_setpoint = '0; prog_hold = '0; temperature = 8'd20;
        cyc(3);
        n_checks++; if (heater !== 1'b0) begin n_fails++; $display("FAIL reset_heater got %b want 0", heater); end
        n_checks++; if (cooler !== 1'b0) begin n_fails++; $display("FAIL reset_cooler got %b want 0", cooler); end
        n_checks++; if (step !== 2'd0) begin n_fails++; $display("FAIL reset_step got %0d want 0", step); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fails++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (state !== 2'd0) begin n_fails++; $display("FAIL reset_state got %0d want 0", state); end
        start = 1'b0; reset = 1'b0;
        cyc(1);
        n_checks++; if (state !== 2'd0) begin n_fails++; $display("FAIL reset_release_state got %0d want 0", state); end
    endtask

    task automatic test_ramp_hold;
        prog(2'd0, 8'd30, 8'd3);
        prog(2'd1, 8'd25, 8'd2);
        prog(2'd2, 8'd20, 8'd0);
        prog(2'd3, 8'd20, 8'd0);
        temperature = 8'd20;
        start = 1'b1; cyc(1); start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL start_busy got %b want 1", busy); end
        n_checks++; if (state !== 2'd1) begin n_fails++; $display("FAIL start_state got %0d want 1", state); end
        n_checks++; if (step !== 2'd0) begin n_fails++; $display("FAIL start_step got %0d want 0", step); end
        cyc(1);
        n_checks++; if (heater !== 1'b1) begin n_fails++; $display("FAIL ramp_heater got %b want 1", heater); end
        n_checks++; if (cooler !== 1'b0) begin n_fails++; $display("FAIL ramp_cooler got %b want 0", cooler); end
        // Tick coincides with HOLD entry and must not be counted.
        temperature = 8'd29; tick = 1'b1; cyc(1); tick = 1'b0;
        n_checks++; if (state !== 2'd2) begin n_fails++; $display("FAIL hold_entry_state got %0d want 2", state); end
        n_checks++; if (heater !== 1'b1) begin n_fails++; $display("FAIL hold_entry_heater got %b want 1", heater); end
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
        end
        n_checks++; if (state !== 2'd2) begin n_fails++; $display("FAIL hold_two_ticks_state got %0d want 2", state); end
        n_checks++; if (step !== 2'd0) begin n_fails++; $display("FAIL hold_two_ticks_step got %0d want 0", step); end
        tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
        n_checks++; if (step !== 2'd1) begin n_fails++; $display("FAIL hold_done_step got %0d want 1", step); end
        n_checks++; if (state !== 2'd1) begin n_fails++; $display("FAIL hold_done_state got %0d want 1", state); end
    endtask

    task automatic test_cool;
        temperature = 8'd40; cyc(1);
        n_checks++; if (cooler !== 1'b1) begin n_fails++; $display("FAIL cool_on got %b want 1", cooler); end
        n_checks++; if (heater !== 1'b0) begin n_fails++; $display("FAIL cool_heater_off got %b want 0", heater); end
        n_checks++; if (state !== 2'd1) begin n_fails++; $display("FAIL cool_ramp_state got %0d want 1", state); end
        temperature = 8'd27; cyc(1);
        n_checks++; if (cooler !== 1'b1) begin n_fails++; $display("FAIL cool_hyst_hold got %b want 1", cooler); end
        n_checks++; if (state !== 2'd2) begin n_fails++; $display("FAIL cool_band_state got %0d want 2", state); end
        temperature = 8'd25; cyc(SETTLE);
        n_checks++; if (cooler !== 1'b0) begin n_fails++; $display("FAIL cool_off got %b want 0", cooler); end
        n_checks++; if (heater !== 1'b0) begin n_fails++; $display("FAIL cool_off_heater got %b want 0", heater); end
    endtask

    task automatic test_abort;
        temperature = 8'd22; cyc(1);
        n_checks++; if (heater !== 1'b1) begin n_fails++; $display("FAIL abort_pre_heater got %b want 1", heater); end
        n_checks++; if (state !== 2'd2) begin n_fails++; $display("FAIL abort_pre_state got %0d want 2", state); end
        abort = 1'b1; cyc(1); abort = 1'b0;
        n_checks++; if (heater !== 1'b0) begin n_fails++; $display("FAIL abort_heater got %b want 0", heater); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++; if (step !== 2'd0) begin n_fails++; $display("FAIL abort_step got %0d want 0", step); end
        n_checks++; if (state !== 2'd0) begin n_fails++; $display("FAIL abort_state got %0d want 0", state); end
        // Start and abort together must stay idle.
        start = 1'b1; abort = 1'b1; cyc(1); start = 1'b0; abort = 1'b0;
        n_checks++; if (state !== 2'd0) begin n_fails++; $display("FAIL start_abort_state got %0d want 0", state); end
    endtask

    task automatic test_dwell;
        logic exp_h;
        prog(2'd0, 8'd30, 8'd200);
        temperature = 8'd20;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(1);
        n_checks++; if (heater !== 1'b1) begin n_fails++; $display("FAIL dwell_heater_on got %b want 1", heater); end
        temperature = 8'd30;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            exp_h = DWELL && (i < 4);
            n_checks++; if (heater !== exp_h) begin n_fails++; $display("FAIL dwell_heater_c%0d got %b want %b", i, heater, exp_h); end
        end
        abort = 1'b1; cyc(1); abort = 1'b0;
    endtask

    task automatic test_full_run;
        int st_exp [10] = '{1, 2, 1, 2, 1, 2, 1, 2, 3, 0};
        int sp_exp [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 0};
        for (int a = 0; a < 4; a++) prog(2'(a), 8'd20, 8'd0);
        temperature = 8'd20;
        start = 1'b1; cyc(1); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (state !== 2'(st_exp[i])) begin n_fails++; $display("FAIL run_state_c%0d got %0d want %0d", i, state, st_exp[i]); end
            n_checks++; if (step !== 2'(sp_exp[i])) begin n_fails++; $display("FAIL run_step_c%0d got %0d want %0d", i, step, sp_exp[i]); end
            n_checks++; if (done !== (i == 8)) begin n_fails++; $display("FAIL run_done_c%0d got %b want %b", i, done, (i == 8)); end
            n_checks++; if (busy !== (i < 8)) begin n_fails++; $display("FAIL run_busy_c%0d got %b want %b", i, busy, (i < 8)); end
            n_checks++; if ((heater | cooler) !== 1'b0) begin n_fails++; $display("FAIL run_act_c%0d got h=%b c=%b want 0", i, heater, cooler); end
            // Table write and start while busy must both be ignored.
            prog_we = (i == 1); prog_addr = 2'd3; prog_setpoint = 8'd20; prog_hold = 8'd50;
            start = (i == 3);
            cyc(1);
        end
        prog_we = 1'b0; start = 1'b0;
    endtask

    task automatic test_boundary;
        prog(2'd0, 8'h7F, 8'd0);
        temperature = 8'h80;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(1);
        n_checks++; if (heater !== 1'b1) begin n_fails++; $display("FAIL edge_heater got %b want 1", heater); end
        n_checks++; if (cooler !== 1'b0) begin n_fails++; $display("FAIL edge_cooler got %b want 0", cooler); end
        n_checks++; if (state !== 2'd1) begin n_fails++; $display("FAIL edge_state got %0d want 1", state); end
        temperature = 8'h7F; cyc(1);
        n_checks++; if (cooler !== 1'b0) begin n_fails++; $display("FAIL edge_top_cooler got %b want 0", cooler); end
        n_checks++; if (heater !== DWELL) begin n_fails++; $display("FAIL edge_top_heater got %b want %b", heater, DWELL); end
        n_checks++; if (state !== 2'd2) begin n_fails++; $display("FAIL edge_top_state got %0d want 2", state); end
        abort = 1'b1; cyc(1); abort = 1'b0;
        n_checks++; if (state !== 2'd0) begin n_fails++; $display("FAIL edge_abort_state got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_ramp_hold();
        test_cool();
        test_abort();
        test_dwell();
        test_full_run();
        test_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
